// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and the RX / read-port FSM state encodings.
package uart_pkg;
  localparam int DEF_CLKS_PER_BIT = 868;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
  typedef enum logic [1:0] {D_IDLE, D_WAIT, D_OUT} rd_state_e;
endpackage

// File: rtl/rx_buf_bl.sv
// rx_buf_bl: simple dual-port byte RAM; registered read returns old data on read-during-write.
module rx_buf_bl
  import uart_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int AW = 11
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/uart_rx_top_buf.sv
// uart_rx_top_buf: 8N1 receiver feeding a ring buffer drained through a req/valid read port.
// Optional stop-bit checking is enabled by defining UART_RX_FRAMING_CHECK_EN.
module uart_rx_top_buf
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DEPTH = 2048,
  parameter int AW = 11
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rxd,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              overrun,
  output logic              frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  logic s1_q, rxs_q;
  rx_state_e rs_q, rs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [DATA_W-1:0] sh_q, sh_d, wdat_q, rd_data_q, mem_rd;
  logic stop_done, byte_done, armed, wr_q, room, do_wr, pop;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] count_q, count_d;
  logic empty_q, ovr_q, rd_valid_q;
  rd_state_e ds_q, ds_d;
  always_comb begin
    rs_d = rs_q;
    cnt_d = cnt_q - CW'(1);
    bit_d = bit_q;
    sh_d = sh_q;
    stop_done = 1'b0;
    case (rs_q)
      R_IDLE: begin
        rs_d = (!rxs_q && armed) ? R_START : R_IDLE;
        cnt_d = CW'(CLKS_PER_BIT / 2);
      end
      R_START: if (cnt_q == '0) begin
        rs_d = rxs_q ? R_IDLE : R_DATA;
        cnt_d = CW'(CLKS_PER_BIT - 1);
        bit_d = '0;
      end
      R_DATA: if (cnt_q == '0) begin
        sh_d = {rxs_q, sh_q[DATA_W-1:1]};
        bit_d = bit_q + 3'd1;
        cnt_d = CW'(CLKS_PER_BIT - 1);
        rs_d = (bit_q == 3'd7) ? R_STOP : R_DATA;
      end
      R_STOP: if (cnt_q == '0) begin
        rs_d = R_IDLE;
        stop_done = 1'b1;
      end
      default: rs_d = R_IDLE;
    endcase
  end
`ifdef UART_RX_FRAMING_CHECK_EN
  logic ferr_q, arm_q;
  assign byte_done = stop_done & rxs_q;
  assign armed = arm_q;
  assign frame_err = ferr_q;
  // after a bad stop bit, wait for the line to go high before arming a new start
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ferr_q <= 1'b0;
      arm_q <= 1'b1;
    end else begin
      ferr_q <= ferr_q | (stop_done & !rxs_q);
      arm_q <= (stop_done & !rxs_q) ? 1'b0 : (rxs_q | arm_q);
    end
  end
`else
  assign byte_done = stop_done;
  assign armed = 1'b1;
  assign frame_err = 1'b0;
`endif
  // space is judged on the registered count, so a same-cycle pop never frees room
  assign room = count_q < DEPTH_C;
  assign do_wr = wr_q & room;
  assign pop = (ds_q == D_IDLE) & rd_req & !empty_q;
  assign wptr_d = do_wr ? ((wptr_q == LAST) ? '0 : wptr_q + AW'(1)) : wptr_q;
  assign rptr_d = pop ? ((rptr_q == LAST) ? '0 : rptr_q + AW'(1)) : rptr_q;
  assign count_d = count_q + (AW+1)'(do_wr) - (AW+1)'(pop);
  assign ds_d = (ds_q == D_IDLE) ? (pop ? D_WAIT : D_IDLE) : (ds_q == D_WAIT) ? D_OUT : D_IDLE;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_q <= 1'b1;
      rxs_q <= 1'b1;
      rs_q <= R_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      wr_q <= 1'b0;
      wdat_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      ovr_q <= 1'b0;
      ds_q <= D_IDLE;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      s1_q <= rxd;
      rxs_q <= s1_q;
      rs_q <= rs_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      wr_q <= byte_done;
      wdat_q <= sh_q;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
      empty_q <= count_d == '0;
      ovr_q <= ovr_q | (wr_q & !room);
      ds_q <= ds_d;
      rd_data_q <= (ds_q == D_WAIT) ? mem_rd : rd_data_q;
      rd_valid_q <= ds_q == D_WAIT;
    end
  end
  rx_buf_bl #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk(clk),
    .we_i(do_wr),
    .waddr_i(wptr_q),
    .wdata_i(wdat_q),
    .re_i(pop),
    .raddr_i(rptr_q),
    .rdata_o(mem_rd)
  );
  assign rd_data = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign empty = empty_q;
  assign overrun = ovr_q;
endmodule
